// File: rtl/wide_add_sequencer.sv
// Wide-operand adder: one 64-bit adder swept limb by limb, LSB first.
// Carry is registered between limbs; valid/ready on both sides.
module adder_64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] s,
  output logic        cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {64'b0, cin};
endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [64*WORDS-1:0] a,
  input  logic [64*WORDS-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [64*WORDS-1:0] sum,
  output logic                cout,
  output logic                busy
);
  localparam int W  = 64 * WORDS;
  localparam int IW = $clog2(WORDS < 2 ? 2 : WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [IW+5:0] lo;
  logic [63:0]   add_a, add_b, add_s;
  logic          add_co;

  assign lo    = {idx_q, 6'b0};
  assign add_a = a_q[lo +: 64];
  assign add_b = b_q[lo +: 64];

  adder_64 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_co)
  );

  assign in_ready  = (state_q == S_IDLE) & ~rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

  // Next-state: accept in IDLE, one limb per cycle in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[lo +: 64] = add_s;
        carry_d = add_co;
        if (idx_q == LAST) begin
          cout_d  = add_co;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer, WORDS=4 and WORDS=1 builds.
// Driver pushes expected results; negedge monitors pop and compare.
module tb_wide_add_sequencer;
  typedef struct {
    logic [255:0] s;
    logic         c;
    int           acc;
  } exp4_t;
  typedef struct {
    logic [63:0] s;
    logic        c;
    int          acc;
  } exp1_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic         iv4, ir4, ov4, or4, cin4, co4, bz4;
  logic [255:0] a4, b4, s4;
  logic         iv1, ir1, ov1, or1, cin1, co1, bz1;
  logic [63:0]  a1, b1, s1;

  exp4_t q4[$];
  exp1_t q1[$];
  exp4_t cur4;
  exp1_t cur1;
  logic  ov4_p = 1'b0;
  logic  ov1_p = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wide_add_sequencer #(.WORDS(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4), .out_ready(or4),
    .sum(s4), .cout(co4), .busy(bz4)
  );

  wide_add_sequencer #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1),
    .sum(s1), .cout(co1), .busy(bz1)
  );

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // WORDS=4 monitor: pop on rising out_valid, check latency and data.
  always @(negedge clk) begin
    if (ov4 && !ov4_p) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w4_unexpected_out actual=%h required=none", s4);
      end else begin
        cur4 = q4.pop_front();
        chk("w4_latency", 256'(cyc - cur4.acc), 256'd4);
      end
    end
    if (ov4) begin
      chk("w4_sum", s4, cur4.s);
      chk("w4_cout", {255'b0, co4}, {255'b0, cur4.c});
    end
    ov4_p <= ov4;
  end

  // WORDS=1 monitor.
  always @(negedge clk) begin
    if (ov1 && !ov1_p) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w1_unexpected_out actual=%h required=none", s1);
      end else begin
        cur1 = q1.pop_front();
        chk("w1_latency", 256'(cyc - cur1.acc), 256'd1);
      end
    end
    if (ov1) begin
      chk("w1_sum", {192'b0, s1}, {192'b0, cur1.s});
      chk("w1_cout", {255'b0, co1}, {255'b0, cur1.c});
    end
    ov1_p <= ov1;
  end

  task automatic send4(input logic [255:0] a, input logic [255:0] b,
                       input logic c, input logic [255:0] es,
                       input logic ec, input bit push);
    exp4_t e;
    int n;
    @(negedge clk);
    a4 = a; b4 = b; cin4 = c; iv4 = 1'b1;
    n = 0;
    while (!ir4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("w4_accept_timeout", 256'd0, 256'd1);
    e.s = es; e.c = ec; e.acc = cyc + 1;
    if (push) q4.push_back(e);
    @(posedge clk);
    #1 iv4 = 1'b0;
  endtask

  task automatic send1(input logic [63:0] a, input logic [63:0] b,
                       input logic c, input logic [63:0] es,
                       input logic ec);
    exp1_t e;
    int n;
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; iv1 = 1'b1;
    n = 0;
    while (!ir1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("w1_accept_timeout", 256'd0, 256'd1);
    e.s = es; e.c = ec; e.acc = cyc + 1;
    q1.push_back(e);
    @(posedge clk);
    #1 iv1 = 1'b0;
  endtask

  task automatic idle4();
    int n = 0;
    @(negedge clk);
    while (!ir4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("w4_idle_timeout", 256'd0, 256'd1);
  endtask

  task automatic idle1();
    int n = 0;
    @(negedge clk);
    while (!ir1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("w1_idle_timeout", 256'd0, 256'd1);
  endtask

  initial begin
    logic [255:0] ones, alt_a, alt_b, bp_a, bp_s;
    int n;
    ones  = {256{1'b1}};
    alt_a = {64{4'hA}};
    alt_b = {64{4'h5}};
    bp_a  = {4{64'h8000_0000_0000_0000}};
    bp_s  = {64'h1, 64'h1, 64'h1, 64'h0};

    rst = 1'b1;
    iv4 = 0; or4 = 1; cin4 = 0; a4 = '0; b4 = '0;
    iv1 = 0; or1 = 1; cin1 = 0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 chk("in_ready_in_rst", {255'b0, ir4}, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {255'b0, ir4}, 256'd1);
    chk("rst_sum", s4, 256'd0);
    chk("rst_cout", {255'b0, co4}, 256'd0);
    chk("rst_out_valid", {255'b0, ov4}, 256'd0);
    chk("rst_busy", {255'b0, bz4}, 256'd0);

    send4(ones, 256'd1, 1'b0, 256'd0, 1'b1, 1'b1);
    idle4();
    send4({192'b0, 64'hFFFF_FFFF_FFFF_FFFF}, 256'd1, 1'b0,
          {128'b0, 64'h1, 64'h0}, 1'b0, 1'b1);
    idle4();
    send4(alt_a, alt_b, 1'b1, 256'd0, 1'b1, 1'b1);
    idle4();
    send4(alt_a, alt_b, 1'b0, ones, 1'b0, 1'b1);
    idle4();

    or4 = 1'b0;
    send4(bp_a, bp_a, 1'b0, bp_s, 1'b1, 1'b1);
    n = 0;
    @(negedge clk);
    while (!ov4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("bp_done_timeout", 256'd0, 256'd1);
    a4 = 256'd100; b4 = 256'd23; cin4 = 1'b1; iv4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", {255'b0, ir4}, 256'd0);
      chk("bp_out_valid", {255'b0, ov4}, 256'd1);
      @(negedge clk);
    end
    begin
      exp4_t e;
      e.s = 256'd124; e.c = 1'b0; e.acc = cyc + 2;
      q4.push_back(e);
    end
    or4 = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", {255'b0, ov4}, 256'd0);
    chk("bp_release_in_ready", {255'b0, ir4}, 256'd1);
    @(posedge clk);
    #1 iv4 = 1'b0;
    idle4();

    send4(ones, 256'd1, 1'b0, 256'd0, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mid_rst_in_ready", {255'b0, ir4}, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", {255'b0, ov4}, 256'd0);
    chk("mid_rst_sum", s4, 256'd0);
    chk("mid_rst_busy", {255'b0, bz4}, 256'd0);
    chk("mid_rst_in_ready_after", {255'b0, ir4}, 256'd1);
    send4(256'd1, 256'd1, 1'b1, 256'd3, 1'b0, 1'b1);
    idle4();

    send1({64{1'b1}}, {64{1'b1}}, 1'b1, {64{1'b1}}, 1'b1);
    idle1();
    send1(64'd5, 64'd7, 1'b0, 64'd12, 1'b0);
    idle1();

    repeat (3) @(negedge clk);
    chk("w4_queue_empty", 256'(q4.size()), 256'd0);
    chk("w1_queue_empty", 256'(q1.size()), 256'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
